cfg_dev_router: RTL and testbench

Parametrised config-space router between the host-interface config port and NUM_TGT AXI-bridge/VPD-class targets (flash, VPD, future devices). It decodes the upper address bits to select a target and drives that target's held-level rden/wren strobe. It returns a one-cycle done pulse with registered read data. Unimplemented or masked targets and unresponsive targets complete with error instead of hanging the host, which replaces the hard-stubbed done=0 behaviour of the earlier wrapper.

---
 rtl/cfg_dev_router_pkg.sv | 19 +
 rtl/cfg_dev_timeout.sv | 27 ++
 rtl/cfg_dev_router.sv | 158 +++++++++++++++
 tb/tb_cfg_dev_router.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_dev_router_pkg.sv
// Shared types and constants for the config-space router.
package cfg_dev_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_UNIMPL  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_dev_timeout.sv
// Loadable down-counter watchdog; expire_o is high while enabled at zero.
module cfg_dev_timeout #(
  parameter int CNT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cfg_dev_router.sv
// Routes host config accesses to one of NUM_TGT targets by upper address bits.
// Handshake: host holds wren/rden until the one-cycle cfg_done, then clears it.
module cfg_dev_router
  import cfg_dev_router_pkg::*;
#(
  parameter int                 NUM_TGT     = 4,
  parameter int                 TGT_ADDR_W  = 14,
  parameter int                 SEL_W       = 2,
  parameter logic [NUM_TGT-1:0] TGT_MASK    = 4'b1110,
  parameter int                 TIMEOUT_CYC = 1024,
  parameter logic [31:0]        ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [SEL_W+TGT_ADDR_W-1:0]   cfg_addr,
  input  logic                          cfg_wren,
  input  logic                          cfg_rden,
  input  logic [31:0]                   cfg_wdata,
  output logic [31:0]                   cfg_rdata,
  output logic                          cfg_done,
  output logic                          err_unimplemented_addr,
  output logic                          err_timeout,
  output logic                          err_protocol,
  output logic                          busy,
  output state_e                        dbg_state_o,
  output logic [NUM_TGT*TGT_ADDR_W-1:0] tgt_addr,
  output logic [NUM_TGT-1:0]            tgt_wren,
  output logic [NUM_TGT-1:0]            tgt_rden,
  output logic [31:0]                   tgt_wdata,
  input  logic [NUM_TGT*32-1:0]         tgt_rdata,
  input  logic [NUM_TGT-1:0]            tgt_done
);

  localparam int ADDR_W = SEL_W + TGT_ADDR_W;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  state_e                  state_q;
  logic [TGT_ADDR_W-1:0]   addr_q;
  logic [SEL_W-1:0]        idx_q;
  logic                    unimpl_q;
  logic [31:0]             wdata_q;
  logic [NUM_TGT-1:0]      tgt_wren_q, tgt_rden_q;
  logic [31:0]             cfg_rdata_q;
  logic                    cfg_done_q, err_unimpl_q, err_timeout_q, err_protocol_q;

  logic [SEL_W-1:0]        idx_in;
  logic                    idx_ok;
  logic [NUM_TGT-1:0]      onehot_in;
  logic                    sel_done;
  logic [31:0]             sel_rdata;
  logic                    tmo_expire;

  assign idx_in = cfg_addr[ADDR_W-1 -: SEL_W];

  // Decode the incoming index and mux the selected target's response.
  always_comb begin
    idx_ok    = 1'b0;
    onehot_in = '0;
    sel_done  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx_in == SEL_W'(i)) begin
        onehot_in[i] = 1'b1;
        idx_ok       = TGT_MASK[i];
      end
      if (idx_q == SEL_W'(i)) begin
        sel_done  = tgt_done[i];
        sel_rdata = tgt_rdata[i*32 +: 32];
      end
    end
  end

  cfg_dev_timeout #(.CNT_W(CNT_W)) u_watchdog (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (state_q == ST_IDLE),
    .load_val_i (CNT_W'(TIMEOUT_CYC - 1)),
    .en_i       ((state_q == ST_ISSUE) && !unimpl_q),
    .expire_o   (tmo_expire)
  );

  // An unimplemented index spends one strobe-less ISSUE cycle so every
  // error completion lands no earlier than a best-case target completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      idx_q          <= '0;
      unimpl_q       <= 1'b0;
      wdata_q        <= '0;
      tgt_wren_q     <= '0;
      tgt_rden_q     <= '0;
      cfg_rdata_q    <= '0;
      cfg_done_q     <= 1'b0;
      err_unimpl_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      cfg_done_q     <= 1'b0;
      err_unimpl_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_wren || cfg_rden) begin
            addr_q         <= cfg_addr[TGT_ADDR_W-1:0];
            idx_q          <= idx_in;
            wdata_q        <= cfg_wdata;
            unimpl_q       <= !idx_ok;
            err_protocol_q <= cfg_wren && cfg_rden;
            state_q        <= ST_ISSUE;
            if (idx_ok) begin
              if (cfg_wren) tgt_wren_q <= onehot_in;
              else          tgt_rden_q <= onehot_in;
            end
          end
        end
        ST_ISSUE: begin
          if (unimpl_q || sel_done || tmo_expire) begin
            tgt_wren_q <= '0;
            tgt_rden_q <= '0;
            cfg_done_q <= 1'b1;
            state_q    <= ST_RESP;
            if (unimpl_q) begin
              err_unimpl_q <= 1'b1;
              cfg_rdata_q  <= ERR_DATA;
            end else if (sel_done) begin
              if (tgt_rden_q != '0) cfg_rdata_q <= sel_rdata;
            end else begin
              err_timeout_q <= 1'b1;
              cfg_rdata_q   <= ERR_DATA;
            end
          end
        end
        ST_RESP:  state_q <= ST_DRAIN;
        ST_DRAIN: if (!cfg_wren && !cfg_rden) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_tgt_addr
    assign tgt_addr[g*TGT_ADDR_W +: TGT_ADDR_W] =
      (tgt_wren_q[g] || tgt_rden_q[g]) ? addr_q : '0;
  end

  assign tgt_wren               = tgt_wren_q;
  assign tgt_rden               = tgt_rden_q;
  assign tgt_wdata              = wdata_q;
  assign cfg_rdata              = cfg_rdata_q;
  assign cfg_done               = cfg_done_q;
  assign err_unimplemented_addr = err_unimpl_q;
  assign err_timeout            = err_timeout_q;
  assign err_protocol           = err_protocol_q;
  assign busy                   = (state_q != ST_IDLE);
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_cfg_dev_router.sv
// Bench for cfg_dev_router: table-driven ops, target responder, done scoreboard.
module tb_cfg_dev_router;
  import cfg_dev_router_pkg::*;

  localparam int NT  = 4;
  localparam int AW  = 14;
  localparam int TMO = 16;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW+1:0]     cfg_addr;
  logic              cfg_wren, cfg_rden;
  logic [31:0]       cfg_wdata, cfg_rdata;
  logic              cfg_done, err_unimplemented_addr, err_timeout, err_protocol, busy;
  state_e            dbg_state;
  logic [NT*AW-1:0]  tgt_addr;
  logic [NT-1:0]     tgt_wren, tgt_rden, tgt_done;
  logic [31:0]       tgt_wdata;
  logic [NT*32-1:0]  tgt_rdata;

  cfg_dev_router #(
    .NUM_TGT(NT), .TGT_ADDR_W(AW), .SEL_W(2), .TGT_MASK(4'b1110),
    .TIMEOUT_CYC(TMO), .ERR_DATA(ERR)
  ) dut (
    .clock(clk), .reset(reset), .cfg_addr(cfg_addr), .cfg_wren(cfg_wren),
    .cfg_rden(cfg_rden), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cfg_done(cfg_done), .err_unimplemented_addr(err_unimplemented_addr),
    .err_timeout(err_timeout), .err_protocol(err_protocol), .busy(busy),
    .dbg_state_o(dbg_state), .tgt_addr(tgt_addr), .tgt_wren(tgt_wren),
    .tgt_rden(tgt_rden), .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata),
    .tgt_done(tgt_done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    bit          wr, rd;
    logic [31:0] wdata, tdata;
    int          delay;      // strobe cycles until target done; 0 = never
    int          hold;       // extra cycles host keeps its strobe after done
    int          exp_done;   // cycle of cfg_done counted from acceptance
    bit          exp_unimpl, exp_tmo, exp_proto;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every cfg_done pops one expected {rdata, unimpl, timeout}
  always @(negedge clk) begin
    if (cfg_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got rdata %0h expected no done", cfg_rdata);
      end else begin
        check("done_result", 64'({cfg_rdata, err_unimplemented_addr, err_timeout}),
              64'(exp_q.pop_front()));
      end
    end
  end

  function automatic vec_t mk(input logic [15:0] addr, input bit wr, input bit rd,
                              input logic [31:0] wdata, input logic [31:0] tdata,
                              input int delay, input int hold, input int exp_done,
                              input bit un, input bit tm, input bit pr);
    vec_t v;
    v.addr = addr; v.wr = wr; v.rd = rd; v.wdata = wdata; v.tdata = tdata;
    v.delay = delay; v.hold = hold; v.exp_done = exp_done;
    v.exp_unimpl = un; v.exp_tmo = tm; v.exp_proto = pr;
    return v;
  endfunction

  // Driver: issue one host op, act as the target, check strobes and timing
  task automatic run_op(input vec_t v);
    int tgt, strobe_cnt, done_cyc, proto_cnt, wrong, addr_bad, wdata_bad, exp_strobes;
    bit valid, active;
    logic [31:0] exp_rd;
    logic [NT-1:0] ok_mask, used, other;
    logic [NT*AW-1:0] exp_ta;
    tgt   = int'(v.addr[15:14]);
    valid = !v.exp_unimpl;
    exp_rd = (v.exp_unimpl || v.exp_tmo) ? ERR : (v.wr ? last_rdata : v.tdata);
    last_rdata = exp_rd;
    exp_q.push_back({exp_rd, v.exp_unimpl, v.exp_tmo});
    @(negedge clk);
    cfg_addr = v.addr; cfg_wren = v.wr; cfg_rden = v.rd; cfg_wdata = v.wdata;
    strobe_cnt = 0; done_cyc = -1; proto_cnt = 0; wrong = 0; addr_bad = 0; wdata_bad = 0;
    ok_mask = valid ? NT'(1 << tgt) : '0;
    for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      tgt_done = '0;
      if (err_protocol) proto_cnt++;
      if (cfg_done) done_cyc = cyc;
      used  = v.wr ? tgt_wren : tgt_rden;
      other = v.wr ? tgt_rden : tgt_wren;
      if ((other != '0) || ((used & ~ok_mask) != '0)) wrong++;
      active = valid && used[tgt];
      exp_ta = active ? ((NT*AW)'(v.addr[13:0]) << (tgt*AW)) : '0;
      if (tgt_addr !== exp_ta) addr_bad++;
      if (active) begin
        strobe_cnt++;
        if (v.wr && tgt_wdata !== v.wdata) wdata_bad++;
        if (v.delay > 0 && strobe_cnt == v.delay) begin
          tgt_done[tgt] = 1'b1;
          tgt_rdata[tgt*32 +: 32] = v.tdata;
        end
      end
      if (cyc == 1) begin
        tgt_done[(tgt+1)%NT] = 1'b1;
        tgt_rdata[((tgt+1)%NT)*32 +: 32] = ~v.tdata;
      end
    end
    tgt_done = '0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done within 100 cycles expected done at %0d", v.exp_done);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    exp_strobes = v.exp_unimpl ? 0 : (v.exp_tmo ? TMO : v.delay);
    check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    check("strobe_cycles", 64'(strobe_cnt), 64'(exp_strobes));
    check("wrong_strobes", 64'(wrong), 64'(0));
    check("tgt_addr", 64'(addr_bad), 64'(0));
    check("tgt_wdata", 64'(wdata_bad), 64'(0));
    check("err_protocol", 64'(proto_cnt), 64'(v.exp_proto));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      tgt_done = '0;
      if (h == 0 && v.exp_tmo) begin
        tgt_done[tgt] = 1'b1;
        tgt_rdata[tgt*32 +: 32] = 32'h1111_1111;
      end
      check("hold_no_strobe", 64'(tgt_wren | tgt_rden), 64'(0));
      check("hold_busy", 64'(busy), 64'(1));
    end
    tgt_done = '0;
    cfg_wren = 1'b0; cfg_rden = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_op", 64'({busy, dbg_state}), 64'({1'b0, ST_IDLE}));
    check("rdata_held", 64'(cfg_rdata), 64'(last_rdata));
  endtask

  vec_t tbl[7];
  vec_t r;

  initial begin
    reset = 1'b1; cfg_addr = '0; cfg_wren = 1'b0; cfg_rden = 1'b0; cfg_wdata = '0;
    tgt_rdata = '0; tgt_done = '0; last_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({cfg_done, err_unimplemented_addr, err_timeout,
                               err_protocol, busy, tgt_wren, tgt_rden}), 64'(0));
    check("reset_rdata", 64'(cfg_rdata), 64'(0));
    check("reset_tgt_addr", 64'(tgt_addr), 64'(0));
    reset = 1'b0;

    tbl[0] = mk(16'h4010, 1, 0, 32'h0,         32'h1234_5678, 5, 0, 6,  0, 0, 0);
    tbl[1] = mk(16'h0123, 1, 0, 32'hCAFE_0001, 32'h0,         0, 0, 2,  1, 0, 0);
    tbl[2] = mk(16'h8ABC, 0, 1, 32'h0,         32'h0,         0, 3, 17, 0, 1, 0);
    tbl[3] = mk(16'hC001, 1, 1, 32'h0000_DEAD, 32'h7777_7777, 1, 0, 2,  0, 0, 1);
    tbl[4] = mk(16'hC3FF, 0, 1, 32'h0,         32'hA5A5_0001, 1, 0, 2,  0, 0, 0);
    tbl[5] = mk(16'h7FFF, 1, 0, 32'h0000_0055, 32'h2222_2222, 3, 0, 4,  0, 0, 0);
    tbl[6] = mk(16'h8004, 0, 1, 32'h0,         32'h0BAD_F00D, 2, 10, 3, 0, 0, 0);
    tbl[0].wr = 0; tbl[0].rd = 1;
    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Reset in the middle of ISSUE drops the strobe and yields no done
    @(negedge clk);
    cfg_addr = 16'h4020; cfg_rden = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_strobe", 64'(tgt_rden), 64'(4'b0010));
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_issue", 64'({tgt_wren, tgt_rden, busy, cfg_done}), 64'(0));
    check("reset_mid_rdata", 64'(cfg_rdata), 64'(0));
    reset = 1'b0; cfg_rden = 1'b0; last_rdata = '0;
    @(negedge clk);
    run_op(mk(16'h4020, 0, 1, 32'h0, 32'h3C3C_5A5A, 2, 0, 3, 0, 0, 0));

    for (int k = 0; k < 6; k++) begin
      r = mk({2'($urandom_range(1, 3)), 14'($urandom_range(0, 16383))},
             1'($urandom_range(0, 1)), 0, $urandom, $urandom, 0, 0, 0, 0, 0, 0);
      r.rd = !r.wr;
      r.delay = $urandom_range(1, 6);
      r.exp_done = r.delay + 1;
      run_op(r);
    end

    repeat (3) @(negedge clk);
    check("leftover_expected", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
